// File: rtl/ecg_pkg.sv
// Shared types and sizing helpers for the ECG post-filter stage.
package ecg_pkg;

  localparam int ECG_SAMPLE_W = 16;
  localparam int ECG_FS_HZ    = 500;

  typedef enum logic [2:0] {
    IDLE,
    DERIV,
    SQUARE,
    ACCUM,
    OUT
  } ecg_state_t;

  // Ceiling log2, never less than 1 so derived vectors stay legal.
  function automatic int clog2_sat(input int n);
    int r;
    r = 1;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/mwi_ring_buffer.sv
// Moving-window history: window_len x q_width RAM with wrapping write pointer
// and saturating fill counter; o_old is zero until the window has filled.
module mwi_ring_buffer
  import ecg_pkg::*;
#(
  parameter int window_len = 75,
  parameter int q_width    = 30
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_rd_en,
  input  logic               i_wr_en,
  input  logic [q_width-1:0] i_wr_data,
  output logic [q_width-1:0] o_old
);

  localparam int PTR_W = clog2_sat(window_len);
  localparam int CNT_W = clog2_sat(window_len + 1);

  logic [q_width-1:0] r_mem [window_len];
  logic [PTR_W-1:0]   r_ptr;
  logic [CNT_W-1:0]   r_fill;
  logic [q_width-1:0] r_rd_data;

  // Contents are never cleared; r_fill masks stale entries after reset.
  always_ff @(posedge clk) begin
    if (i_wr_en) r_mem[r_ptr] <= i_wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr     <= '0;
      r_fill    <= '0;
      r_rd_data <= '0;
    end else begin
      if (i_rd_en) r_rd_data <= r_mem[r_ptr];
      if (i_wr_en) begin
        r_ptr <= (r_ptr == PTR_W'(window_len - 1)) ? '0 : r_ptr + PTR_W'(1);
        if (r_fill != CNT_W'(window_len)) r_fill <= r_fill + CNT_W'(1);
      end
    end
  end

  assign o_old = (r_fill == CNT_W'(window_len)) ? r_rd_data : '0;

endmodule

// File: rtl/ecg_deriv_square_mwi_axis.sv
// Pan-Tompkins derivative, squaring and moving-window integrator, one sample
// in flight. Optional debug taps under ECG_MWI_DEBUG_EN.
//   state  | meaning
//   IDLE   | ready for a sample, history shifts on handshake
//   DERIV  | 5-point derivative
//   SQUARE | square, fetch oldest window entry
//   ACCUM  | update window sum, write ring, register output
//   OUT    | present result until downstream accepts
module ecg_deriv_square_mwi_axis
  import ecg_pkg::*;
#(
  parameter int inout_width = ECG_SAMPLE_W,
  parameter int window_len  = 75,
  parameter int out_shift   = 6,
  parameter int out_width   = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          s_axis_tvalid,
  input  logic signed [inout_width-1:0] s_axis_tdata,
  output logic                          s_axis_tready,
  output logic                          m_axis_tvalid,
  output logic [out_width-1:0]          m_axis_tdata,
  input  logic                          m_axis_tready
`ifdef ECG_MWI_DEBUG_EN
  ,
  output logic signed [inout_width-1:0] dbg_deriv,
  output logic [2*inout_width-3:0]      dbg_square
`endif
);

  localparam int Q_W   = 2 * inout_width - 2;
  localparam int SUM_W = Q_W + clog2_sat(window_len);
  localparam int DW    = inout_width + 3;
  localparam int EXT_W = (SUM_W > out_width) ? SUM_W : out_width;

  ecg_state_t r_state, w_state_nxt;

  logic signed [inout_width-1:0] r_x [5];
  logic signed [inout_width-1:0] r_d;
  logic [Q_W-1:0]                r_q;
  logic [SUM_W-1:0]              r_sum;
  logic [out_width-1:0]          r_tdata;

  logic signed [DW-1:0] w_acc;
  logic [Q_W-1:0]       w_square;
  logic [Q_W-1:0]       w_old;
  logic [SUM_W-1:0]     w_sum_nxt;
  logic [EXT_W-1:0]     w_shifted;
  logic [out_width-1:0] w_sat;
  logic                 w_rd_en;
  logic                 w_wr_en;

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt   = r_state;
    s_axis_tready = 1'b0;
    m_axis_tvalid = 1'b0;
    w_rd_en       = 1'b0;
    w_wr_en       = 1'b0;
    unique case (r_state)
      IDLE: begin
        s_axis_tready = 1'b1;
        if (s_axis_tvalid) w_state_nxt = DERIV;
      end
      DERIV:  w_state_nxt = SQUARE;
      SQUARE: begin
        w_rd_en     = 1'b1;
        w_state_nxt = ACCUM;
      end
      ACCUM: begin
        w_wr_en     = 1'b1;
        w_state_nxt = OUT;
      end
      OUT: begin
        m_axis_tvalid = 1'b1;
        if (m_axis_tready) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Three guard bits cover 2+1+1+2 = 6x the input range before the >>> 3.
  assign w_acc = (DW'(r_x[0]) <<< 1) + DW'(r_x[1]) - DW'(r_x[3]) - (DW'(r_x[4]) <<< 1);

  // |d| <= 3/4 full scale, so d*d fits Q_W bits unsigned.
  assign w_square = Q_W'(r_d * r_d);

  assign w_sum_nxt = r_sum + SUM_W'(r_q) - SUM_W'(w_old);
  assign w_shifted = EXT_W'(w_sum_nxt >> out_shift);
  assign w_sat     = (w_shifted > EXT_W'({out_width{1'b1}})) ? {out_width{1'b1}}
                                                             : out_width'(w_shifted);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 5; i++) r_x[i] <= '0;
      r_d     <= '0;
      r_q     <= '0;
      r_sum   <= '0;
      r_tdata <= '0;
    end else begin
      unique case (r_state)
        IDLE: if (s_axis_tvalid) begin
          r_x[0] <= s_axis_tdata;
          for (int i = 1; i < 5; i++) r_x[i] <= r_x[i-1];
        end
        DERIV:  r_d <= inout_width'(w_acc >>> 3);
        SQUARE: r_q <= w_square;
        ACCUM: begin
          r_sum   <= w_sum_nxt;
          r_tdata <= w_sat;
        end
        default: ;
      endcase
    end
  end

  assign m_axis_tdata = r_tdata;

  mwi_ring_buffer #(
    .window_len (window_len),
    .q_width    (Q_W)
  ) u_ring (
    .clk        (clk),
    .rst        (rst),
    .i_rd_en    (w_rd_en),
    .i_wr_en    (w_wr_en),
    .i_wr_data  (r_q),
    .o_old      (w_old)
  );

`ifdef ECG_MWI_DEBUG_EN
  logic signed [inout_width-1:0] r_dbg_deriv;
  logic [Q_W-1:0]                r_dbg_square;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_dbg_deriv  <= '0;
      r_dbg_square <= '0;
    end else if (r_state == ACCUM) begin
      r_dbg_deriv  <= r_d;
      r_dbg_square <= r_q;
    end
  end

  assign dbg_deriv  = r_dbg_deriv;
  assign dbg_square = r_dbg_square;
`endif

endmodule

// File: tb/tb_ecg_deriv_square_mwi_axis.sv
// Scoreboard bench: instance A at defaults, instance B with a 4-sample window,
// 16-bit output and no shift to reach wrap and saturation quickly.
module tb_ecg_deriv_square_mwi_axis;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst     [2];
  logic               s_valid [2];
  logic signed [15:0] s_data  [2];
  logic               m_ready [2];

  logic        a_s_ready, a_m_valid, b_s_ready, b_m_valid;
  logic [31:0] a_m_data;
  logic [15:0] b_m_data;

  int n_cmp = 0;
  int n_bad = 0;

  int     hist [2][5];
  longint qh0[$], qh1[$];
  longint exp0[$], exp1[$];

  ecg_deriv_square_mwi_axis u_a (
    .clk(clk), .rst(rst[0]),
    .s_axis_tvalid(s_valid[0]), .s_axis_tdata(s_data[0]), .s_axis_tready(a_s_ready),
    .m_axis_tvalid(a_m_valid), .m_axis_tdata(a_m_data), .m_axis_tready(m_ready[0])
  );

  ecg_deriv_square_mwi_axis #(
    .inout_width(16), .window_len(4), .out_shift(0), .out_width(16)
  ) u_b (
    .clk(clk), .rst(rst[1]),
    .s_axis_tvalid(s_valid[1]), .s_axis_tdata(s_data[1]), .s_axis_tready(b_s_ready),
    .m_axis_tvalid(b_m_valid), .m_axis_tdata(b_m_data), .m_axis_tready(m_ready[1])
  );

  function automatic logic f_sready(input int sel);
    return (sel == 0) ? a_s_ready : b_s_ready;
  endfunction
  function automatic logic f_mvalid(input int sel);
    return (sel == 0) ? a_m_valid : b_m_valid;
  endfunction
  function automatic logic [31:0] f_mdata(input int sel);
    return (sel == 0) ? a_m_data : {16'd0, b_m_data};
  endfunction

  function automatic void model_reset(input int sel);
    for (int i = 0; i < 5; i++) hist[sel][i] = 0;
    if (sel == 0) begin qh0.delete(); exp0.delete(); end
    else          begin qh1.delete(); exp1.delete(); end
  endfunction

  function automatic void model_push(input int sel, input int x);
    int     d;
    longint q, s, o, maxv;
    int     win, sh;
    win  = (sel == 0) ? 75 : 4;
    sh   = (sel == 0) ? 6 : 0;
    maxv = (sel == 0) ? 64'hFFFF_FFFF : 64'hFFFF;
    for (int i = 4; i > 0; i--) hist[sel][i] = hist[sel][i-1];
    hist[sel][0] = x;
    d = (2 * hist[sel][0] + hist[sel][1] - hist[sel][3] - 2 * hist[sel][4]) >>> 3;
    q = longint'(d) * longint'(d);
    s = 0;
    if (sel == 0) begin
      qh0.push_back(q);
      if (qh0.size() > win) void'(qh0.pop_front());
      foreach (qh0[i]) s += qh0[i];
    end else begin
      qh1.push_back(q);
      if (qh1.size() > win) void'(qh1.pop_front());
      foreach (qh1[i]) s += qh1[i];
    end
    o = s >> sh;
    if (o > maxv) o = maxv;
    if (sel == 0) exp0.push_back(o);
    else          exp1.push_back(o);
  endfunction

  function automatic logic [31:0] pop_exp(input int sel);
    longint e;
    e = 64'hDEAD_BEEF;
    if (sel == 0 && exp0.size() > 0) e = exp0.pop_front();
    if (sel == 1 && exp1.size() > 0) e = exp1.pop_front();
    return 32'(e);
  endfunction

  // One transaction; stalls m_ready for 'stall' cycles once OUT is reached.
  task automatic xact(input int sel, input int x, input int stall,
                      output logic [31:0] data, output int lat, output bit stable);
    int n;
    stable = 1'b1;
    m_ready[sel] = (stall == 0);
    s_valid[sel] = 1'b1;
    s_data[sel]  = 16'(x);
    model_push(sel, x);
    n = 0;
    while (!f_sready(sel) && n < 50) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    s_valid[sel] = 1'b0;
    lat = 0;
    while (!f_mvalid(sel) && lat < 50) begin @(posedge clk); #1; lat++; end
    data = f_mdata(sel);
    for (int i = 0; i < stall; i++) begin
      @(posedge clk); #1;
      if (f_mvalid(sel) !== 1'b1 || f_mdata(sel) !== data || f_sready(sel) !== 1'b0)
        stable = 1'b0;
    end
    m_ready[sel] = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst[0] = 1'b1; rst[1] = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst[0] = 1'b0; rst[1] = 1'b0;
    model_reset(0); model_reset(1);
    @(posedge clk); #1;
    n_cmp++; if (a_s_ready !== 1'b1) begin n_bad++; $display("FAIL reset_s_ready got %b want 1", a_s_ready); end
    n_cmp++; if (a_m_valid !== 1'b0) begin n_bad++; $display("FAIL reset_m_valid got %b want 0", a_m_valid); end
    n_cmp++; if (a_m_data !== 32'd0) begin n_bad++; $display("FAIL reset_m_data got %0d want 0", a_m_data); end
    n_cmp++; if (b_m_data !== 16'd0) begin n_bad++; $display("FAIL reset_b_m_data got %0d want 0", b_m_data); end
  endtask

  task automatic test_step(input int sel, input int x, input int cnt, input string tag);
    logic [31:0] data, e;
    logic [31:0] k_step [5];
    int lat;
    bit st;
    k_step = '{32'd625, 32'd2031, 32'd3437, 32'd4062, 32'd4062};
    for (int i = 0; i < cnt; i++) begin
      xact(sel, x, 0, data, lat, st);
      e = pop_exp(sel);
      n_cmp++;
      if (data !== e) begin n_bad++; $display("FAIL %s[%0d] got %0d want %0d", tag, i, data, e); end
      if (sel == 0 && i < 5) begin
        n_cmp++;
        if (data !== k_step[i]) begin n_bad++; $display("FAIL %s_const[%0d] got %0d want %0d", tag, i, data, k_step[i]); end
      end
      if (i == 0) begin
        n_cmp++;
        if (lat != 3) begin n_bad++; $display("FAIL %s_latency got %0d want 4", tag, lat + 1); end
      end
    end
  endtask

  task automatic test_impulse(input int sel, input int zeros, input string tag);
    logic [31:0] data, e;
    int lat;
    bit st;
    for (int i = 0; i <= zeros; i++) begin
      xact(sel, (i == 0) ? 800 : 0, 0, data, lat, st);
      e = pop_exp(sel);
      n_cmp++;
      if (data !== e) begin n_bad++; $display("FAIL %s[%0d] got %0d want %0d", tag, i, data, e); end
    end
  endtask

  task automatic test_window_wrap();
    test_impulse(1, 9, "wrap_w4");
    test_impulse(0, 80, "wrap_w75");
  endtask

  task automatic test_backpressure();
    logic [31:0] data, e;
    int lat;
    bit st;
    xact(0, 1234, 10, data, lat, st);
    e = pop_exp(0);
    n_cmp++; if (data !== e) begin n_bad++; $display("FAIL bp_data got %0d want %0d", data, e); end
    n_cmp++; if (st !== 1'b1) begin n_bad++; $display("FAIL bp_stable got %b want 1", st); end
    n_cmp++; if (lat != 3) begin n_bad++; $display("FAIL bp_latency got %0d want 4", lat + 1); end
    n_cmp++; if (a_s_ready !== 1'b1) begin n_bad++; $display("FAIL bp_s_ready_after got %b want 1", a_s_ready); end
    n_cmp++; if (a_m_valid !== 1'b0) begin n_bad++; $display("FAIL bp_m_valid_after got %b want 0", a_m_valid); end
  endtask

  task automatic test_saturation_reset();
    logic [31:0] data, e;
    int lat, n;
    bit st;
    for (int i = 0; i < 6; i++) begin
      xact(1, (i % 2 == 0) ? 32767 : -32768, 0, data, lat, st);
      e = pop_exp(1);
      n_cmp++;
      if (data !== e) begin n_bad++; $display("FAIL sat[%0d] got %0d want %0d", i, data, e); end
      n_cmp++;
      if (data !== 32'd65535) begin n_bad++; $display("FAIL sat_max[%0d] got %0d want 65535", i, data); end
    end
    // Reset while a result is waiting in OUT; the sample is discarded.
    m_ready[1] = 1'b0;
    s_valid[1] = 1'b1;
    s_data[1]  = 16'sd3000;
    n = 0;
    while (!b_s_ready && n < 50) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    s_valid[1] = 1'b0;
    n = 0;
    while (!b_m_valid && n < 50) begin @(posedge clk); #1; n++; end
    n_cmp++; if (b_m_valid !== 1'b1) begin n_bad++; $display("FAIL rst_pre_valid got %b want 1", b_m_valid); end
    rst[1] = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if (b_m_valid !== 1'b0) begin n_bad++; $display("FAIL rst_m_valid got %b want 0", b_m_valid); end
    n_cmp++; if (b_m_data !== 16'd0) begin n_bad++; $display("FAIL rst_m_data got %0d want 0", b_m_data); end
    rst[1] = 1'b0;
    m_ready[1] = 1'b1;
    model_reset(1);
    @(posedge clk); #1;
    n_cmp++; if (b_s_ready !== 1'b1) begin n_bad++; $display("FAIL rst_s_ready got %b want 1", b_s_ready); end
    test_step(1, 800, 6, "post_rst_step");
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      rst[i] = 1'b1; s_valid[i] = 1'b0; s_data[i] = '0; m_ready[i] = 1'b1;
    end
    test_reset();
    test_step(0, 800, 10, "step_pos");
    test_reset();
    test_step(0, -800, 10, "step_neg");
    test_reset();
    test_window_wrap();
    test_backpressure();
    test_saturation_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout compared %0d", n_cmp);
    $fatal(1, "timeout");
  end

endmodule
